// File: rtl/tti_tx_unpacker_pkg.sv
// Shared types for the TTI TX path: descriptor layout and unpacker FSM states.
package tti_tx_unpacker_pkg;

    localparam int unsigned TtiTxDescWidth = 32;
    localparam int unsigned TtiTxLenWidth  = 16;

    typedef struct packed {
        logic [TtiTxDescWidth-1:TtiTxLenWidth] reserved;
        logic [TtiTxLenWidth-1:0]              data_length;
    } tti_tx_desc_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND,
        DRAIN
    } tti_tx_unpack_state_e;

endpackage

// File: rtl/tti_tx_unpacker.sv
// TTI TX unpacker: pops one descriptor per private read, then serialises the
// covered data words LSB-byte-first toward the target bus FSM. An early abort
// drains the remaining words so the two queues stay descriptor-aligned.
module tti_tx_unpacker
    import tti_tx_unpacker_pkg::*;
#(
    parameter int unsigned TxDescDataWidth = TtiTxDescWidth,
    parameter int unsigned TxDataWidth     = 32,
    parameter int unsigned LenWidth        = TtiTxLenWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       tx_desc_rvalid_i,
    output logic                       tx_desc_rready_o,
    input  logic [TxDescDataWidth-1:0] tx_desc_rdata_i,
    input  logic                       tx_rvalid_i,
    output logic                       tx_rready_o,
    input  logic [TxDataWidth-1:0]     tx_rdata_i,
    input  logic                       xfer_start_i,
    input  logic                       xfer_abort_i,
    output logic                       byte_valid_o,
    input  logic                       byte_ready_i,
    output logic [7:0]                 byte_o,
    output logic                       byte_last_o,
    output logic                       no_desc_o,
    output logic                       xfer_done_o,
    output logic                       xfer_aborted_o,
    output logic                       busy_o
);

    localparam int unsigned BytesPerWord = TxDataWidth / 8;
    localparam int unsigned IdxWidth     = (BytesPerWord > 1) ? $clog2(BytesPerWord) : 1;
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BytesPerWord - 1);

    tti_tx_unpack_state_e r_state, w_state_nxt;

    logic [LenWidth-1:0]    r_len_left;
    logic [LenWidth-2:0]    r_words_left;
    logic [TxDataWidth-1:0] r_word;
    logic [IdxWidth-1:0]    r_byte_idx;
    logic                   r_no_desc;
    logic                   r_done;
    logic                   r_aborted;

    logic [LenWidth-1:0]    w_desc_len;
    logic [LenWidth:0]      w_len_round;
    logic [LenWidth-2:0]    w_desc_words;
    logic                   w_abort;
    logic                   w_byte_acc;
    logic                   w_last_byte;
    logic                   w_desc_pop;
    logic                   w_word_pop;
    logic                   w_set_no_desc;
    logic                   w_set_done;
    logic                   w_set_aborted;
    logic                   w_unused_rsvd;

    assign w_desc_len    = tx_desc_rdata_i[LenWidth-1:0];
    assign w_unused_rsvd = ^tx_desc_rdata_i[TxDescDataWidth-1:LenWidth];
    assign w_len_round   = {1'b0, w_desc_len} + (LenWidth+1)'(BytesPerWord - 1);
    assign w_desc_words  = (LenWidth-1)'(w_len_round / (LenWidth+1)'(BytesPerWord));

    // Abort only matters while a transfer is moving data; it outranks any handshake.
    assign w_abort     = xfer_abort_i && ((r_state == FETCH) || (r_state == SEND));
    assign w_byte_acc  = (r_state == SEND) && byte_ready_i && !w_abort;
    assign w_last_byte = (r_len_left == LenWidth'(1));

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:  if (xfer_start_i && tx_desc_rvalid_i && (w_desc_len != '0)) w_state_nxt = FETCH;
            FETCH: if (w_abort)          w_state_nxt = DRAIN;
                   else if (tx_rvalid_i) w_state_nxt = SEND;
            SEND:  if (w_abort)          w_state_nxt = DRAIN;
                   else if (w_byte_acc) begin
                       if (w_last_byte)                  w_state_nxt = IDLE;
                       else if (r_byte_idx == LastIdx)   w_state_nxt = FETCH;
                   end
            DRAIN: if (r_words_left == '0) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Queue pops and completion pulse requests for the current state.
    always_comb begin
        w_desc_pop    = 1'b0;
        w_word_pop    = 1'b0;
        w_set_no_desc = 1'b0;
        w_set_done    = 1'b0;
        w_set_aborted = 1'b0;
        unique case (r_state)
            IDLE: if (xfer_start_i) begin
                w_desc_pop    = tx_desc_rvalid_i;
                w_set_no_desc = !tx_desc_rvalid_i;
                w_set_done    = tx_desc_rvalid_i && (w_desc_len == '0);
            end
            FETCH: w_word_pop = tx_rvalid_i && !w_abort;
            DRAIN: begin
                w_word_pop    = tx_rvalid_i && (r_words_left != '0);
                w_set_done    = (r_words_left == '0);
                w_set_aborted = (r_words_left == '0);
            end
            default: ;
        endcase
        if ((r_state == SEND) && w_byte_acc && w_last_byte) w_set_done = 1'b1;
    end

    // Length/word counters, latched data word and registered status pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len_left   <= '0;
            r_words_left <= '0;
            r_word       <= '0;
            r_byte_idx   <= '0;
            r_no_desc    <= 1'b0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
        end else begin
            r_no_desc <= w_set_no_desc;
            r_done    <= w_set_done;
            r_aborted <= w_set_aborted;
            if (w_desc_pop) begin
                r_len_left   <= w_desc_len;
                r_words_left <= w_desc_words;
            end
            if (w_word_pop) r_words_left <= r_words_left - (LenWidth-1)'(1);
            if ((r_state == FETCH) && w_word_pop) begin
                r_word     <= tx_rdata_i;
                r_byte_idx <= '0;
            end
            if (w_byte_acc) begin
                r_len_left <= r_len_left - LenWidth'(1);
                r_byte_idx <= r_byte_idx + IdxWidth'(1);
            end
            if (w_abort) r_word <= '0;
        end
    end

    assign tx_desc_rready_o = w_desc_pop;
    assign tx_rready_o      = w_word_pop;
    assign byte_valid_o     = (r_state == SEND);
    assign byte_o           = r_word[8*r_byte_idx +: 8];
    assign byte_last_o      = (r_state == SEND) && w_last_byte;
    assign no_desc_o        = r_no_desc;
    assign xfer_done_o      = r_done;
    assign xfer_aborted_o   = r_aborted;
    assign busy_o           = (r_state != IDLE);

endmodule

// File: tb/tb_tti_tx_unpacker.sv
// Directed bench for tti_tx_unpacker with behavioural descriptor/data queues.
module tb_tti_tx_unpacker;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        tx_desc_rvalid_i;
    logic        tx_desc_rready_o;
    logic [31:0] tx_desc_rdata_i;
    logic        tx_rvalid_i;
    logic        tx_rready_o;
    logic [31:0] tx_rdata_i;
    logic        xfer_start_i;
    logic        xfer_abort_i;
    logic        byte_valid_o;
    logic        byte_ready_i;
    logic [7:0]  byte_o;
    logic        byte_last_o;
    logic        no_desc_o;
    logic        xfer_done_o;
    logic        xfer_aborted_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    tti_tx_unpacker #(
        .TxDescDataWidth(32),
        .TxDataWidth    (32),
        .LenWidth       (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .tx_desc_rvalid_i(tx_desc_rvalid_i),
        .tx_desc_rready_o(tx_desc_rready_o),
        .tx_desc_rdata_i (tx_desc_rdata_i),
        .tx_rvalid_i     (tx_rvalid_i),
        .tx_rready_o     (tx_rready_o),
        .tx_rdata_i      (tx_rdata_i),
        .xfer_start_i    (xfer_start_i),
        .xfer_abort_i    (xfer_abort_i),
        .byte_valid_o    (byte_valid_o),
        .byte_ready_i    (byte_ready_i),
        .byte_o          (byte_o),
        .byte_last_o     (byte_last_o),
        .no_desc_o       (no_desc_o),
        .xfer_done_o     (xfer_done_o),
        .xfer_aborted_o  (xfer_aborted_o),
        .busy_o          (busy_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] dq[$];
    logic [31:0] wq[$];
    logic [7:0]  got[$];
    logic [31:0] got_last;
    int          acc_cyc[$];
    int          cyc_no, st_cyc, done_cyc;
    int          done_cnt, nodesc_cnt, dpop_cnt, wpop_cnt, bv_cnt, busy_cnt;
    logic        done_ab;
    logic        hold;
    logic        s_bv, p_bv, p_ready, p_abort;
    logic [7:0]  p_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        got.delete();
        acc_cyc.delete();
        got_last   = '0;
        done_cnt   = 0;
        nodesc_cnt = 0;
        dpop_cnt   = 0;
        wpop_cnt   = 0;
        bv_cnt     = 0;
        busy_cnt   = 0;
        done_ab    = 1'b0;
        done_cyc   = -1;
    endtask

    // One clock cycle: present queue heads, sample at negedge+1, pop after posedge.
    task automatic cyc();
        logic dpop, wpop;
        tx_desc_rvalid_i = (dq.size() > 0);
        tx_desc_rdata_i  = (dq.size() > 0) ? dq[0] : 32'h0;
        tx_rvalid_i      = !hold && (wq.size() > 0);
        tx_rdata_i       = (wq.size() > 0) ? wq[0] : 32'h0;
        #1;
        if (p_bv && !p_ready && !p_abort) begin
            chk("hold_valid", {31'h0, byte_valid_o}, 32'h1);
            chk("hold_byte", {24'h0, byte_o}, {24'h0, p_byte});
        end
        dpop = tx_desc_rready_o && tx_desc_rvalid_i;
        wpop = tx_rready_o && tx_rvalid_i;
        if (byte_valid_o && byte_ready_i && !xfer_abort_i) begin
            got_last[got.size()] = byte_last_o;
            got.push_back(byte_o);
            acc_cyc.push_back(cyc_no);
        end
        if (xfer_done_o) begin
            done_cnt++;
            done_ab  = xfer_aborted_o;
            done_cyc = cyc_no;
        end
        nodesc_cnt += int'(no_desc_o);
        bv_cnt     += int'(byte_valid_o);
        busy_cnt   += int'(busy_o);
        dpop_cnt   += int'(dpop);
        wpop_cnt   += int'(wpop);
        s_bv    = byte_valid_o;
        p_bv    = byte_valid_o;
        p_ready = byte_ready_i;
        p_abort = xfer_abort_i;
        p_byte  = byte_o;
        @(posedge clk_i);
        if (dpop) void'(dq.pop_front());
        if (wpop) void'(wq.pop_front());
        cyc_no++;
        @(negedge clk_i);
    endtask

    task automatic start();
        st_cyc = cyc_no;
        xfer_start_i = 1'b1;
        cyc();
        xfer_start_i = 1'b0;
    endtask

    task automatic run_to_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) cyc();
        cyc();
        chk("done_count", done_cnt, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {22'h0, byte_valid_o, byte_last_o, byte_o}, 32'h0);
        chk({tag, "_status"}, {26'h0, no_desc_o, xfer_done_o, xfer_aborted_o, busy_o,
                                tx_desc_rready_o, tx_rready_o}, 32'h0);
    endtask

    initial begin
        logic aborted;
        rst_ni = 1'b0;
        tx_desc_rvalid_i = 1'b0; tx_desc_rdata_i = '0;
        tx_rvalid_i = 1'b0; tx_rdata_i = '0;
        xfer_start_i = 1'b0; xfer_abort_i = 1'b0; byte_ready_i = 1'b0;
        hold = 1'b0; p_bv = 1'b0; p_ready = 1'b0; p_abort = 1'b0; p_byte = '0;
        cyc_no = 0;
        clr();
        repeat (3) @(negedge clk_i);
        #1 chk_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        // len=6 across two words, ready held high.
        clr();
        dq.push_back(32'h0000_0006);
        wq.push_back(32'h4433_2211);
        wq.push_back(32'h0000_6655);
        byte_ready_i = 1'b1;
        start();
        run_to_done(20);
        chk("t1_nbytes", got.size(), 6);
        chk("t1_b0", {24'h0, got[0]}, 32'h11);
        chk("t1_b1", {24'h0, got[1]}, 32'h22);
        chk("t1_b2", {24'h0, got[2]}, 32'h33);
        chk("t1_b3", {24'h0, got[3]}, 32'h44);
        chk("t1_b4", {24'h0, got[4]}, 32'h55);
        chk("t1_b5", {24'h0, got[5]}, 32'h66);
        chk("t1_last", got_last, 32'h20);
        chk("t1_first_lat", acc_cyc[0] - st_cyc, 2);
        chk("t1_bubble", acc_cyc[4] - acc_cyc[3], 2);
        chk("t1_done_cyc", done_cyc - st_cyc, 9);
        chk("t1_aborted", {31'h0, done_ab}, 32'h0);
        chk("t1_pops", {dpop_cnt[15:0], wpop_cnt[15:0]}, {16'd1, 16'd2});
        chk("t1_q_empty", dq.size() + wq.size(), 0);

        // Start with an empty descriptor queue.
        clr();
        start();
        repeat (4) cyc();
        chk("t2_no_desc", nodesc_cnt, 1);
        chk("t2_pops", dpop_cnt + wpop_cnt, 0);
        chk("t2_busy", busy_cnt, 0);
        chk("t2_done", done_cnt, 0);

        // Zero-length descriptor.
        clr();
        dq.push_back(32'hABCD_0000);
        start();
        repeat (3) cyc();
        chk("t3_dpop", dpop_cnt, 1);
        chk("t3_wpop", wpop_cnt, 0);
        chk("t3_done", done_cnt, 1);
        chk("t3_done_cyc", done_cyc - st_cyc, 1);
        chk("t3_bv", bv_cnt, 0);

        // len=12, abort after five bytes, then len=1.
        clr();
        dq.push_back(32'h0000_000C);
        wq.push_back(32'h0403_0201);
        wq.push_back(32'h0807_0605);
        wq.push_back(32'h0C0B_0A09);
        aborted = 1'b0;
        start();
        for (int i = 0; i < 40 && done_cnt == 0; i++) begin
            if (got.size() == 5 && !aborted) begin
                xfer_abort_i = 1'b1;
                cyc();
                xfer_abort_i = 1'b0;
                aborted = 1'b1;
                cyc();
                chk("t4_bv_drop", {31'h0, s_bv}, 32'h0);
            end else begin
                cyc();
            end
        end
        cyc();
        chk("t4_done", done_cnt, 1);
        chk("t4_aborted", {31'h0, done_ab}, 32'h1);
        chk("t4_nbytes", got.size(), 5);
        chk("t4_b4", {24'h0, got[4]}, 32'h05);
        chk("t4_wpop", wpop_cnt, 3);
        chk("t4_q_empty", dq.size() + wq.size(), 0);
        clr();
        dq.push_back(32'h0000_0001);
        wq.push_back(32'h0000_00AA);
        start();
        run_to_done(20);
        chk("t4b_nbytes", got.size(), 1);
        chk("t4b_byte", {24'h0, got[0]}, 32'hAA);
        chk("t4b_last", got_last, 32'h1);
        chk("t4b_aborted", {31'h0, done_ab}, 32'h0);

        // len=4 with the data word held back and a random byte_ready.
        clr();
        dq.push_back(32'h0000_0004);
        wq.push_back(32'h0302_0100);
        hold = 1'b1;
        start();
        for (int i = 0; i < 10; i++) begin
            byte_ready_i = $urandom_range(0, 1) == 1;
            cyc();
        end
        chk("t5_wait_bv", bv_cnt, 0);
        chk("t5_wait_wpop", wpop_cnt, 0);
        hold = 1'b0;
        for (int i = 0; i < 60 && done_cnt == 0; i++) begin
            byte_ready_i = (i >= 30) || ($urandom_range(0, 1) == 1);
            cyc();
        end
        byte_ready_i = 1'b1;
        cyc();
        chk("t5_done", done_cnt, 1);
        chk("t5_nbytes", got.size(), 4);
        chk("t5_bytes", {got[3], got[2], got[1], got[0]}, 32'h0302_0100);
        chk("t5_last", got_last, 32'h8);

        // Reset while a byte is waiting, then a fresh len=2 transfer.
        clr();
        dq.push_back(32'h0000_0004);
        wq.push_back(32'h0D0C_0B0A);
        byte_ready_i = 1'b0;
        start();
        cyc();
        cyc();
        chk("t6_in_send", {30'h0, s_bv, busy_o}, 32'h3);
        rst_ni = 1'b0;
        #1 chk_all_zero("t6_reset_async");
        @(posedge clk_i);
        #1 chk_all_zero("t6_reset_edge");
        @(negedge clk_i);
        rst_ni = 1'b1;
        p_bv = 1'b0;
        clr();
        dq.push_back(32'h0000_0002);
        wq.push_back(32'h0000_BEEF);
        byte_ready_i = 1'b1;
        start();
        run_to_done(20);
        chk("t6_nbytes", got.size(), 2);
        chk("t6_bytes", {16'h0, got[1], got[0]}, 32'h0000_BEEF);
        chk("t6_last", got_last, 32'h2);
        chk("t6_aborted", {31'h0, done_ab}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
